// File: rtl/vr_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// vr_muldiv_pkg
// Shared encodings for the iterative multiply/divide unit.
//   OP_*  : operation select carried on the unit's 'op' port
//   S_*   : sequencer state encoding (IDLE -> RUN -> FIX -> DONE)
// -----------------------------------------------------------------------------
package vr_muldiv_pkg;

    // Operation encodings: op[1] selects divide, op[0] selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

endpackage

// File: rtl/vr_cond_neg.sv
// -----------------------------------------------------------------------------
// vr_cond_neg
// Combinational conditional two's-complement negate.
// Ports:
//   value  : input  [W-1:0]  operand
//   negate : input           1 = output -value, 0 = pass value through
//   result : output [W-1:0]  negate ? -value : value (wraps for the most
//                            negative value, which is what the unit relies on)
// -----------------------------------------------------------------------------
module vr_cond_neg
    import vr_muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/vr_muldiv_unit.sv
// -----------------------------------------------------------------------------
// vr_muldiv_unit
// Iterative (one bit per cycle) integer multiply/divide unit fed from the
// register file read ports, holding its result in HI/LO.
//
// Ports:
//   CLK         : input            clock, all state on posedge
//   RST         : input            synchronous active-high reset
//   start       : input            request an operation (sampled in IDLE only)
//   op          : input  [1:0]     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A           : input  [WIDTH]   multiplicand / dividend (RD1)
//   B           : input  [WIDTH]   multiplier / divisor (RD2)
//   busy        : output           operation in progress (RUN and FIX)
//   done        : output           one-cycle pulse, HI/LO hold the new result
//   div_by_zero : output           qualifies done: divide with B == 0
//   hi          : output [WIDTH]   upper product half or remainder
//   lo          : output [WIDTH]   lower product half or quotient
//
// Optional build macro VR_MULDIV_TRACE_EN: when defined, a simulation-only
// trace line "op A B -> hi lo dbz" (hex) is printed in every done cycle.
// Cycle behaviour is identical with or without it.
// -----------------------------------------------------------------------------
module vr_muldiv_unit
    import vr_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               sign_a;
    logic               sign_b;
    logic               dbz_q;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [WIDTH-1:0]   opnd;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {remainder, dividend bits shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // ---- operand magnitudes at acceptance ----
    logic             in_signed;
    logic             in_div;
    logic             in_b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign in_signed = ~op[0];
    assign in_div    = op[1];
    assign in_b_zero = (B == '0);

    vr_cond_neg #(.W(WIDTH)) u_mag_a (
        .value  (A),
        .negate (in_signed & A[WIDTH-1]),
        .result (a_mag)
    );

    vr_cond_neg #(.W(WIDTH)) u_mag_b (
        .value  (B),
        .negate (in_signed & B[WIDTH-1]),
        .result (b_mag)
    );

    // ---- one iteration of shift-add multiply / restoring divide ----
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_step;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    // and bit WIDTH of the difference is a reliable "went negative" flag.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};

    always_comb begin
        acc_step = acc;
        if (op_q[1]) begin
            if (!div_trial[WIDTH])
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // ---- sign correction applied in FIX ----
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    vr_cond_neg #(.W(2*WIDTH)) u_fix_prod (
        .value  (acc),
        .negate ((op_q == OP_MULT) & (sign_a ^ sign_b)),
        .result (prod_fix)
    );

    vr_cond_neg #(.W(WIDTH)) u_fix_quo (
        .value  (acc[WIDTH-1:0]),
        .negate ((op_q == OP_DIV) & (sign_a ^ sign_b)),
        .result (quo_fix)
    );

    // Remainder takes the sign of the dividend.
    vr_cond_neg #(.W(WIDTH)) u_fix_rem (
        .value  (acc[2*WIDTH-1:WIDTH]),
        .negate ((op_q == OP_DIV) & sign_a),
        .result (rem_fix)
    );

    // ---- sequencer and state registers ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz_q  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_a <= in_signed & A[WIDTH-1];
                        sign_b <= in_signed & B[WIDTH-1];
                        cnt    <= '0;
                        if (in_div && in_b_zero) begin
                            // Divide by zero skips iteration; FIX copies the
                            // raw dividend into HI, so keep A unmodified.
                            dbz_q <= 1'b1;
                            opnd  <= '0;
                            acc   <= {{WIDTH{1'b0}}, A};
                            state <= S_FIX;
                        end else if (in_div) begin
                            dbz_q <= 1'b0;
                            opnd  <= b_mag;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            state <= S_RUN;
                        end else begin
                            dbz_q <= 1'b0;
                            opnd  <= a_mag;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (dbz_q) begin
                        hi_q <= acc[WIDTH-1:0];
                        lo_q <= '1;
                    end else if (!op_q[1]) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state == S_RUN) || (state == S_FIX);
    assign done        = (state == S_DONE);
    assign div_by_zero = done & dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

`ifdef VR_MULDIV_TRACE_EN
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_raw <= '0;
            b_raw <= '0;
        end else if (state == S_IDLE && start) begin
            a_raw <= A;
            b_raw <= B;
        end
    end

    always_ff @(posedge CLK) begin
        if (done)
            $display("%h %h %h -> %h %h %h", op_q, a_raw, b_raw, hi_q, lo_q, dbz_q);
    end
`else
`endif

endmodule

// File: tb/tb_vr_muldiv_unit.sv
module tb_vr_muldiv_unit;

    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;

    vr_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural values.
    // Returns {dbz, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        logic [63:0]     q64;
        logic [63:0]     m64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = '0;
        case (o)
            2'd0: begin
                r = sa * sb;
                model = {1'b0, r};
            end
            2'd1: begin
                r = ua * ub;
                model = {1'b0, r};
            end
            2'd2: begin
                if (b == 0) model = {1'b1, a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q64 = sq;
                    m64 = sr;
                    model = {1'b0, m64[31:0], q64[31:0]};
                end
            end
            default: begin
                if (b == 0) model = {1'b1, a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    q64 = uq;
                    m64 = ur;
                    model = {1'b0, m64[31:0], q64[31:0]};
                end
            end
        endcase
    endfunction

    // Issue one operation, disturb inputs afterwards, and check latency,
    // busy length, result, flag and the post-done hold.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] exp;
        int          cycles;
        int          busy_cnt;
        int          exp_lat;
        logic [31:0] hi_seen;
        logic [31:0] lo_seen;
        exp     = model(o, a, b);
        exp_lat = exp[64] ? 2 : WIDTH + 2;
        @(negedge CLK);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge CLK); #1;
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        cycles = 1; busy_cnt = 0;
        while (!done && cycles < 100) begin
            chk("dbz_low_while_not_done", {63'd0, div_by_zero}, 64'd0);
            if (busy) busy_cnt++;
            // A start with different operands while busy must be ignored.
            if (cycles == 1) begin
                start = 1'b1; op = 2'($urandom); A = $urandom; B = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cycles++;
        end
        start = 1'b0;
        chk("done_latency", 64'(cycles), 64'(exp_lat));
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        chk("busy_low_in_done", {63'd0, busy}, 64'd0);
        chk("hi", {32'd0, hi}, {32'd0, exp[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, exp[31:0]});
        chk("dbz", {63'd0, div_by_zero}, {63'd0, exp[64]});
        hi_seen = hi; lo_seen = lo;
        @(posedge CLK); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("hi_hold", {32'd0, hi}, {32'd0, hi_seen});
        chk("lo_hold", {32'd0, lo}, {32'd0, lo_seen});
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int          pulses;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        RST = 1'b1; start = 1'b0; op = 2'd0; A = '0; B = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed cases.
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        chk("multu_max_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        do_op(2'b11, 32'd100, 32'd7);
        chk("divu_lo", {32'd0, lo}, 64'd14);
        chk("divu_hi", {32'd0, hi}, 64'd2);
        do_op(2'b11, 32'h0000_1234, 32'd0);
        chk("dbz_hi", {32'd0, hi}, 64'h1234);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
        do_op(2'b10, 32'hFFFF_FFF0, 32'd0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // Randomised operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            if (ro[1] && $urandom_range(0, 5) == 0) rb = '0;
            do_op(ro, ra, rb);
        end

        // start held high: next operation begins in the IDLE cycle after done.
        @(negedge CLK);
        start = 1'b1; op = 2'b01; A = 32'd6; B = 32'd7;
        pulses = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge CLK); #1;
        end
        chk("hold_first_done", {63'd0, done}, 64'd1);
        chk("hold_first_lo", {32'd0, lo}, 64'd42);
        @(posedge CLK); #1;
        chk("hold_idle_gap", {63'd0, busy}, 64'd0);
        @(posedge CLK); #1;
        chk("hold_restart_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge CLK); #1;
        end
        chk("hold_second_done", {63'd0, done}, 64'd1);
        chk("hold_second_lo", {32'd0, lo}, 64'd42);
        @(posedge CLK); #1;

        // Reset mid-operation: result must never arrive.
        @(negedge CLK);
        start = 1'b1; op = 2'b01; A = 32'd3; B = 32'd5;
        @(posedge CLK); #1;                 // cycle N+1
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;                                 // cycle N+5
        start = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9;
        @(posedge CLK); #1;                 // N+6
        start = 1'b0;
        chk("mid_busy", {63'd0, busy}, 64'd1);
        repeat (4) @(posedge CLK);
        #1;                                 // N+10
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        for (int c = 0; c < 45; c++) begin
            if (done) pulses++;
            @(posedge CLK); #1;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        chk("abort_hi_after", {32'd0, hi}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
